// File: rtl/sha3_pkg.sv
// Shared SHA-3 types, rate constants, absorb FSM encoding and lane decode.
// A "lane" is one 64-bit word; a "plane" is the five lanes of one y row, indexed by x.
package sha3_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [4:0] plane_t;

  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_FIRE,
    ST_WAIT
  } absorb_state_e;

  typedef struct packed {
    logic [2:0] y;
    logic [2:0] x;
  } lane_pos_t;

  // Flat lane index runs x-fastest: index i sits at row i/5, column i%5.
  function automatic lane_pos_t lane_decode(input logic [4:0] idx);
    lane_pos_t p;
    p.y = 3'(idx / 5'd5);
    p.x = 3'(idx % 5'd5);
    return p;
  endfunction

endpackage

// File: rtl/sha3_absorb_if.sv
// Bundle between the message source / permutation and the absorb stage.
// master is the surrounding datapath; slave is sha3_absorb.
interface sha3_absorb_if;
  import sha3_pkg::*;

  logic   start;
  lane_t  iword;
  logic   ivalid;
  logic   ilast;
  logic   iready;
  plane_t osa, osb, osc, osd, ose;
  logic   sample;
  plane_t isa, isb, isc, isd, ise;
  logic   perm_good;
  logic   digest_valid;

  modport master (
    output start, iword, ivalid, ilast,
    output isa, isb, isc, isd, ise, perm_good,
    input  iready, osa, osb, osc, osd, ose, sample, digest_valid
  );

  modport slave (
    input  start, iword, ivalid, ilast,
    input  isa, isb, isc, isd, ise, perm_good,
    output iready, osa, osb, osc, osd, ose, sample, digest_valid
  );

endinterface

// File: rtl/sha3_absorb.sv
// XORs message lanes into the rate part of the Keccak state and hands the state to the permutation.
// Latency: sample one cycle after the last lane of a block; os* follow is* one cycle after perm_good.
// Backpressure: iready only in ABSORB (one lane per cycle); held low from the fire until perm_good.
module sha3_absorb
  import sha3_pkg::*;
#(
  parameter int RATE_LANES = RATE_SHA3_256
) (
  input  logic         clk,
  input  logic         rst,
  sha3_absorb_if.slave bus
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  absorb_state_e fsm;
  logic [4:0]    cnt;
  logic          last_q;
  plane_t        st [5];
  logic          iready_q;
  logic          sample_q;
  logic          digest_q;

  lane_pos_t pos;
  logic      hs;

  assign pos = lane_decode(cnt);
  // iready_q is high only in ABSORB, so this is also the state qualifier.
  assign hs  = bus.ivalid && iready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm      <= ST_IDLE;
      cnt      <= '0;
      last_q   <= 1'b0;
      iready_q <= 1'b0;
      sample_q <= 1'b0;
      digest_q <= 1'b0;
      for (int y = 0; y < 5; y++) st[y] <= '0;
    end else begin
      sample_q <= 1'b0;
      digest_q <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (bus.start) begin
            for (int y = 0; y < 5; y++) st[y] <= '0;
            cnt      <= '0;
            last_q   <= 1'b0;
            iready_q <= 1'b1;
            fsm      <= ST_ABSORB;
          end
        end
        ST_ABSORB: begin
          if (hs) begin
            st[pos.y][pos.x] <= st[pos.y][pos.x] ^ bus.iword;
            if (cnt == LAST_IDX) begin
              cnt      <= '0;
              last_q   <= bus.ilast;
              iready_q <= 1'b0;
              sample_q <= 1'b1;
              fsm      <= ST_FIRE;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ST_FIRE: begin
          fsm <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.perm_good) begin
            st[0] <= bus.isa;
            st[1] <= bus.isb;
            st[2] <= bus.isc;
            st[3] <= bus.isd;
            st[4] <= bus.ise;
            if (last_q) begin
              digest_q <= 1'b1;
              fsm      <= ST_IDLE;
            end else begin
              iready_q <= 1'b1;
              fsm      <= ST_ABSORB;
            end
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign bus.osa          = st[0];
  assign bus.osb          = st[1];
  assign bus.osc          = st[2];
  assign bus.osd          = st[3];
  assign bus.ose          = st[4];
  assign bus.iready       = iready_q;
  assign bus.sample       = sample_q;
  assign bus.digest_valid = digest_q;

endmodule

// File: tb/tb_sha3_absorb.sv
// Bench for sha3_absorb: 17-lane and 9-lane instances against a flat-lane reference state.
module tb_sha3_absorb;
  import sha3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic   start17, start9, ivalid, ilast, perm_good;
  lane_t  iword;
  plane_t is_p [5];

  sha3_absorb_if b17 ();
  sha3_absorb_if b9 ();

  assign b17.start = start17;   assign b9.start = start9;
  assign b17.iword = iword;     assign b9.iword = iword;
  assign b17.ivalid = ivalid;   assign b9.ivalid = ivalid;
  assign b17.ilast = ilast;     assign b9.ilast = ilast;
  assign b17.perm_good = perm_good; assign b9.perm_good = perm_good;
  assign b17.isa = is_p[0]; assign b17.isb = is_p[1]; assign b17.isc = is_p[2];
  assign b17.isd = is_p[3]; assign b17.ise = is_p[4];
  assign b9.isa = is_p[0];  assign b9.isb = is_p[1];  assign b9.isc = is_p[2];
  assign b9.isd = is_p[3];  assign b9.ise = is_p[4];

  sha3_absorb #(.RATE_LANES(17)) dut17 (.clk(clk), .rst(rst), .bus(b17));
  sha3_absorb #(.RATE_LANES(9))  dut9  (.clk(clk), .rst(rst), .bus(b9));

  int     sel;
  logic   iready, sample, dv;
  plane_t os_p [5];

  always_comb begin
    if (sel == 0) begin
      iready = b17.iready; sample = b17.sample; dv = b17.digest_valid;
      os_p[0] = b17.osa; os_p[1] = b17.osb; os_p[2] = b17.osc;
      os_p[3] = b17.osd; os_p[4] = b17.ose;
    end else begin
      iready = b9.iready; sample = b9.sample; dv = b9.digest_valid;
      os_p[0] = b9.osa; os_p[1] = b9.osb; os_p[2] = b9.osc;
      os_p[3] = b9.osd; os_p[4] = b9.ose;
    end
  end

  int    n_cmp = 0;
  int    n_bad = 0;
  lane_t m   [25];   // expected state, flat lane index i = 5*y + x
  lane_t ret [25];   // state the fake permutation hands back

  typedef struct {
    lane_t w;
    logic  last;
    int    y;
    int    x;
  } vec_t;
  vec_t tbl [17];

  function automatic int rate();
    return (sel == 0) ? 17 : 9;
  endfunction

  function automatic lane_t rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input lane_t act, input lane_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_lanes(input string tag);
    for (int i = 0; i < 25; i++)
      chk($sformatf("%s lane%0d", tag, i), os_p[i/5][i%5], m[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    if (sel == 0) start17 = 1'b1; else start9 = 1'b1;
    tick();
    start17 = 1'b0;
    start9  = 1'b0;
    for (int i = 0; i < 25; i++) m[i] = '0;
    chk1("start iready", iready, 1'b1);
  endtask

  // Offer one lane, wait (bounded) for iready, then report whether sample followed.
  task automatic send(input lane_t w, input logic l, input logic expect_fire);
    int k;
    ivalid = 1'b1;
    iword  = w;
    ilast  = l;
    k = 0;
    while (!iready && k < 50) begin
      tick();
      k++;
    end
    chk1("send iready", iready, 1'b1);
    if (iready) tick();
    ivalid = 1'b0;
    ilast  = 1'b0;
    chk1("sample after lane", sample, expect_fire);
  endtask

  // Called in the sample cycle. Plays the permutation: returns ret[] after `delay` WAIT cycles.
  task automatic perm_return(input int delay, input logic final_blk, input logic stray);
    tick();
    chk1("sample single pulse", sample, 1'b0);
    for (int d = 0; d < delay; d++) begin
      if (stray) begin
        ivalid = 1'b1;
        iword  = rnd64();
      end
      tick();
    end
    ivalid = 1'b0;
    chk1("wait iready", iready, 1'b0);
    chk1("wait no digest", dv, 1'b0);
    chk_lanes("wait");
    for (int i = 0; i < 25; i++) is_p[i/5][i%5] = ret[i];
    perm_good = 1'b1;
    tick();
    perm_good = 1'b0;
    for (int i = 0; i < 25; i++) m[i] = ret[i];
    chk_lanes("perm load");
    chk1("digest on perm", dv, final_blk);
    chk1("iready on perm", iready, !final_blk);
    if (final_blk) begin
      tick();
      chk1("digest single pulse", dv, 1'b0);
      chk1("idle iready", iready, 1'b0);
    end
  endtask

  task automatic rand_msg(input int nblk);
    lane_t w;
    logic  l;
    do_start();
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < rate(); i++) begin
        repeat ($urandom_range(0, 2)) tick();
        w = rnd64();
        if (i == rate() - 1) l = (b == nblk - 1);
        else l = ($urandom_range(0, 7) == 0);
        send(w, l, i == rate() - 1);
        m[i] ^= w;
      end
      chk_lanes("rand fire");
      for (int i = 0; i < 25; i++) ret[i] = rnd64();
      perm_return($urandom_range(0, 4), b == nblk - 1, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    rst = 1'b0; sel = 0;
    start17 = 1'b0; start9 = 1'b0; ivalid = 1'b0; ilast = 1'b0; perm_good = 1'b0;
    iword = '0;
    for (int y = 0; y < 5; y++) is_p[y] = '0;
    for (int i = 0; i < 25; i++) m[i] = '0;
    for (int i = 0; i < 17; i++) begin
      tbl[i].w    = lane_t'(i + 1);
      tbl[i].last = (i == 16);
      tbl[i].y    = i / 5;
      tbl[i].x    = i % 5;
    end
    tick(); tick();

    // Reset state on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk1("reset iready", iready, 1'b0);
      chk1("reset sample", sample, 1'b0);
      chk1("reset digest", dv, 1'b0);
      chk_lanes("reset");
    end
    rst = 1'b1;
    sel = 0;
    tick();

    // Single 17-lane block 0x1..0x11 from the vector table.
    do_start();
    foreach (tbl[i]) send(tbl[i].w, tbl[i].last, tbl[i].last);
    foreach (tbl[i]) chk($sformatf("tbl lane%0d", i), os_p[tbl[i].y][tbl[i].x], tbl[i].w);
    for (int i = 17; i < 25; i++) chk($sformatf("tbl cap%0d", i), os_p[i/5][i%5], 64'h0);
    for (int i = 0; i < 17; i++) m[i] = lane_t'(i + 1);
    for (int i = 0; i < 25; i++) ret[i] = rnd64();
    perm_return(2, 1'b1, 1'b0);

    // Two blocks: all-ones return, stray ivalid in WAIT, stray perm_good in ABSORB.
    do_start();
    for (int i = 0; i < 17; i++) begin
      send(64'h5, 1'b0, i == 16);
      m[i] ^= 64'h5;
    end
    for (int i = 0; i < 25; i++) ret[i] = '1;
    perm_return(3, 1'b0, 1'b1);
    for (int y = 0; y < 5; y++) is_p[y] = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    perm_good = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(64'h1, 1'b0, 1'b0);
      m[i] ^= 64'h1;
    end
    perm_good = 1'b0;
    chk_lanes("stray perm_good");
    for (int i = 4; i < 17; i++) begin
      send(64'h1, i == 16, i == 16);
      m[i] ^= 64'h1;
    end
    chk(("second block lane0"), os_p[0][0], 64'hFFFF_FFFF_FFFF_FFFE);
    chk(("second block cap24"), os_p[4][4], 64'hFFFF_FFFF_FFFF_FFFF);
    chk_lanes("second block");
    for (int i = 0; i < 25; i++) ret[i] = rnd64();
    perm_return(1, 1'b1, 1'b0);

    // Asynchronous reset after five lanes aborts the message.
    do_start();
    for (int i = 0; i < 5; i++) send(lane_t'(64'hA0 + i), 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 25; i++) m[i] = '0;
    chk1("midrst iready", iready, 1'b0);
    chk1("midrst sample", sample, 1'b0);
    chk1("midrst digest", dv, 1'b0);
    chk_lanes("midrst");
    #2 rst = 1'b1;
    tick();
    for (int y = 0; y < 5; y++) is_p[y] = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    perm_good = 1'b1;
    tick();
    perm_good = 1'b0;
    chk1("post-rst perm digest", dv, 1'b0);
    chk1("post-rst iready", iready, 1'b0);
    chk_lanes("post-rst perm");
    tick();
    chk1("post-rst digest later", dv, 1'b0);

    // ilast on lane 3 is ignored; only the real final lane ends the message.
    do_start();
    for (int i = 0; i < 17; i++) begin
      send(lane_t'(64'h100 + i), i == 3, i == 16);
      m[i] ^= lane_t'(64'h100 + i);
    end
    for (int i = 0; i < 25; i++) ret[i] = rnd64();
    perm_return(2, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      send(lane_t'(64'h200 + i), i == 16, i == 16);
      m[i] ^= lane_t'(64'h200 + i);
    end
    for (int i = 0; i < 25; i++) ret[i] = rnd64();
    perm_return(0, 1'b1, 1'b0);

    // Nine-lane instance: fire after nine lanes, capacity untouched by absorption.
    sel = 1;
    #0;
    do_start();
    for (int i = 0; i < 9; i++) begin
      send(lane_t'(64'h900 + i), 1'b0, i == 8);
      m[i] ^= lane_t'(64'h900 + i);
    end
    chk_lanes("r9 block1");
    for (int i = 0; i < 25; i++) ret[i] = rnd64();
    perm_return(1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      send(64'h3, i == 8, i == 8);
      m[i] ^= 64'h3;
    end
    chk_lanes("r9 block2");
    for (int i = 0; i < 25; i++) ret[i] = rnd64();
    perm_return(2, 1'b1, 1'b0);

    // Randomised messages on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      for (int n = 0; n < 5; n++) rand_msg($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
